bft_stream_packetizer: RTL and testbench
========================================

// Module: bft_stream_packetizer
// PURPOSE
//  Transmit end of a leaf link: accepts 32-bit words from a user operator over an ap_vld/ap_ack
//  handshake, wraps each in a 49-bit BFT packet (dest leaf/port/address header) and drives it into
//  the fat tree. Credit-based flow control: never sends more words than receiver BRAM can hold;
//  credits are restored by freespace-update packets returned from the destination leaf.
// PARAMETERS
//  PACKET_BITS    49  packet width
//  PAYLOAD_BITS   32  payload width
//  NUM_LEAF_BITS  4   dest leaf field width
//  NUM_PORT_BITS  4   dest port field width
//  NUM_ADDR_BITS  7   receiver BRAM address width
//  INIT_CREDITS   128 credits after reset (= 2**NUM_ADDR_BITS, receiver buffer depth)
// PORTS
//  clk_bft           in  1   single clock
//  reset_bft         in  1   reset; synchronous, active-low
//  dest_leaf         in  4   destination leaf; sampled only in IDLE
//  dest_port         in  4   destination port; sampled only in IDLE; must be nonzero
//  din_leaf_user2tx  in  32  user word
//  vld_user2tx       in  1   user word valid; held with data until ack
//  ack_tx2user       out 1   one-cycle accept pulse
//  dout_tx2bft       out 49  packet to tree; bit 48 = valid
//  din_bft2tx        in  49  packets from tree (credit returns)
//  credits           out 8   current credit count
//  credit_err        out 1   sticky: credit return overflowed INIT_CREDITS
// BEHAVIOUR
//  Packet: [48] valid, [47:44] leaf, [43:40] port, [39:33] addr, [32] parity/0, [31:0] payload.
//  Reset (reset_bft==0 at posedge): state IDLE, ack_tx2user=0, dout_tx2bft=0, credits=INIT_CREDITS,
//   addr=0, credit_err=0. Reset mid-packet drops in-flight word; no partial output.
//  FSM: IDLE -> RUN next cycle (latches dest_leaf/dest_port). RUN -> STALL when credits reach 0.
//   STALL -> RUN the cycle after credits become nonzero. No exit back to IDLE except reset.
//  Accept at cycle N iff state==RUN, credits>0, vld_user2tx==1, ack_tx2user==0 at N.
//   At N+1: ack_tx2user=1 for exactly one cycle; dout_tx2bft holds packet with valid=1 for exactly
//   one cycle, then returns to all-zero. Latency 1; max rate 1 word / 2 cycles (no accept while ack high).
//  addr increments per sent packet, wraps 127 -> 0.
//  Credit return: din_bft2tx[48]==1 and port field==0 -> increment = din_bft2tx[7:0]; other packets ignored.
//  Credits: send decrements 1; same-cycle send+return -> credits + inc - 1. Result > INIT_CREDITS ->
//   saturate at INIT_CREDITS, set credit_err. Credits never underflow (accept gated by credits>0).
//  Word presented with credits==0: held, not acked, until credit arrives; no data loss.
// CONFIGURATION
//  BFT_TX_PARITY_EN defined: bit 32 = even parity (XOR) over payload[31:0].
//  Not defined: bit 32 driven 0. No other difference.
// STRUCTURE
//  Package bft_pkg: packet field LSB/MSB localparams, CTRL_PORT=0, FSM state enum (IDLE/RUN/STALL).
//  Sub-module bft_tx_credit_counter: saturating add/decrement, credit_err sticky, credits output.
// TESTING
//  Reset, dest_leaf=3, dest_port=2, send 0xDEADBEEF -> dout=valid|leaf3|port2|addr0|0xDEADBEEF 1 cycle after accept, ack 1 pulse.
//  Stream 128 words, no returns -> 128 packets, credits=0, STALL, word 129 held unacked indefinitely.
//  In STALL, return packet port0 payload 64 -> word 129 sent with addr 0 (wrap), credits end 63.
//  Return payload 10 while credits=125 -> credits=128, credit_err=1, stays 1 until reset.
//  Send+return(1) same cycle at credits=5 -> credits stays 5.
//  With BFT_TX_PARITY_EN, payload 0x00000007 -> bit32=1; without, bit32=0.

Source files
------------

// File: rtl/bft_pkg.sv
// Shared definitions for the BFT leaf transmit path: packet field positions,
// credit sizing and the packetizer FSM state type.
package bft_pkg;

  localparam int PACKET_BITS   = 49;
  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_LEAF_BITS = 4;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;
  localparam int CREDIT_BITS   = 8;
  localparam int INIT_CREDITS  = 2 ** NUM_ADDR_BITS;

  // Packet layout, MSB first: valid | leaf | port | addr | parity | payload
  localparam int VALID_BIT   = 48;
  localparam int LEAF_MSB    = 47;
  localparam int LEAF_LSB    = 44;
  localparam int PORT_MSB    = 43;
  localparam int PORT_LSB    = 40;
  localparam int ADDR_MSB    = 39;
  localparam int ADDR_LSB    = 33;
  localparam int PARITY_BIT  = 32;
  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_LSB = 0;

  // Packets addressed to this port carry freespace (credit) updates.
  localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } tx_state_t;

endpackage

// File: rtl/bft_tx_credit_counter.sv
// Credit counter for the transmit leaf: decrements per sent word, adds returned
// freespace, saturates at the receiver buffer depth and flags overflow (sticky).
module bft_tx_credit_counter
  import bft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dec,
  input  logic [CREDIT_BITS-1:0] inc,
  output logic [CREDIT_BITS-1:0] credits,
  output logic                   credit_err
);

  // Two extra bits hold credits + inc (up to 128 + 255) without wrapping.
  logic [CREDIT_BITS+1:0] sum;

  always_comb begin
    sum = {2'b00, credits} + {2'b00, inc} - {{(CREDIT_BITS+1){1'b0}}, dec};
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits    <= CREDIT_BITS'(INIT_CREDITS);
      credit_err <= 1'b0;
    end else if (sum > (CREDIT_BITS+2)'(INIT_CREDITS)) begin
      credits    <= CREDIT_BITS'(INIT_CREDITS);
      credit_err <= 1'b1;
    end else begin
      credits    <= sum[CREDIT_BITS-1:0];
    end
  end

endmodule

// File: rtl/bft_stream_packetizer.sv
// BFT leaf transmitter: wraps user words into 49-bit packets under credit flow control.
// Define BFT_TX_PARITY_EN to drive even parity of the payload on packet bit 32.
module bft_stream_packetizer
  import bft_pkg::*;
(
  input  logic                     clk_bft,
  input  logic                     reset_bft,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2tx,
  input  logic                     vld_user2tx,
  output logic                     ack_tx2user,
  output logic [PACKET_BITS-1:0]   dout_tx2bft,
  input  logic [PACKET_BITS-1:0]   din_bft2tx,
  output logic [CREDIT_BITS-1:0]   credits,
  output logic                     credit_err
);

  tx_state_t                state, state_next;
  logic [NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_PORT_BITS-1:0] port_q;
  logic [NUM_ADDR_BITS-1:0] addr;
  logic                     accept;
  logic                     ret_vld;
  logic [CREDIT_BITS-1:0]   credit_inc;
  logic                     parity;

  // Only the count byte of a return packet matters; the rest is dropped.
  logic unused_ret_bits;
  assign unused_ret_bits = ^{din_bft2tx[LEAF_MSB:LEAF_LSB], din_bft2tx[ADDR_MSB:8]};

  // The ack term limits the rate to one word per two cycles, so a word held
  // valid through its ack cycle is never taken twice.
  assign accept = (state == ST_RUN) && (credits != '0) && vld_user2tx && !ack_tx2user;

  assign ret_vld    = din_bft2tx[VALID_BIT] && (din_bft2tx[PORT_MSB:PORT_LSB] == CTRL_PORT);
  assign credit_inc = ret_vld ? din_bft2tx[CREDIT_BITS-1:0] : '0;

`ifdef BFT_TX_PARITY_EN
  assign parity = ^din_leaf_user2tx;
`else
  assign parity = 1'b0;
`endif

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_RUN;
      ST_RUN:   if (credits == '0) state_next = ST_STALL;
      ST_STALL: if (credits != '0) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it sits inside the clocked branch and
  // is absent from the sensitivity list.
  always_ff @(posedge clk_bft) begin
    if (!reset_bft) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge clk_bft) begin
    if (!reset_bft) begin
      ack_tx2user <= 1'b0;
      dout_tx2bft <= '0;
      addr        <= '0;
      leaf_q      <= '0;
      port_q      <= '0;
    end else begin
      ack_tx2user <= accept;
      if (state == ST_IDLE) begin
        leaf_q <= dest_leaf;
        port_q <= dest_port;
      end
      if (accept) begin
        dout_tx2bft <= {1'b1, leaf_q, port_q, addr, parity, din_leaf_user2tx};
        addr        <= addr + 1'b1;
      end else begin
        dout_tx2bft <= '0;
      end
    end
  end

  bft_tx_credit_counter u_credit (
    .clk        (clk_bft),
    .rst_n      (reset_bft),
    .dec        (accept),
    .inc        (credit_inc),
    .credits    (credits),
    .credit_err (credit_err)
  );

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Directed bench for bft_stream_packetizer: packet format, credit stall/resume,
// address wrap, credit saturation and simultaneous send/return.
module tb_bft_stream_packetizer;

  logic        clk_bft = 1'b0;
  logic        reset_bft;
  logic [3:0]  dest_leaf;
  logic [3:0]  dest_port;
  logic [31:0] din_leaf_user2tx;
  logic        vld_user2tx;
  logic        ack_tx2user;
  logic [48:0] dout_tx2bft;
  logic [48:0] din_bft2tx;
  logic [7:0]  credits;
  logic        credit_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_bft = ~clk_bft;

  bft_stream_packetizer dut (
    .clk_bft          (clk_bft),
    .reset_bft        (reset_bft),
    .dest_leaf        (dest_leaf),
    .dest_port        (dest_port),
    .din_leaf_user2tx (din_leaf_user2tx),
    .vld_user2tx      (vld_user2tx),
    .ack_tx2user      (ack_tx2user),
    .dout_tx2bft      (dout_tx2bft),
    .din_bft2tx       (din_bft2tx),
    .credits          (credits),
    .credit_err       (credit_err)
  );

  task automatic check(input string tag, input logic [48:0] got, input logic [48:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] pkt(input logic [3:0] leaf, input logic [3:0] port,
                                     input logic [6:0] a, input logic [31:0] d);
    logic p;
`ifdef BFT_TX_PARITY_EN
    p = ^d;
`else
    p = 1'b0;
`endif
    return {1'b1, leaf, port, a, p, d};
  endfunction

  function automatic logic [48:0] ret_pkt(input logic [3:0] port, input logic [7:0] n);
    return {1'b1, 4'd0, port, 7'd0, 1'b0, 24'd0, n};
  endfunction

  task automatic tick();
    @(posedge clk_bft);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] leaf, input logic [3:0] port);
    reset_bft        = 1'b0;
    vld_user2tx      = 1'b0;
    din_leaf_user2tx = '0;
    din_bft2tx       = '0;
    dest_leaf        = leaf;
    dest_port        = port;
    repeat (2) tick();
    check("rst_ack", 49'(ack_tx2user), 49'd0);
    check("rst_dout", dout_tx2bft, 49'd0);
    check("rst_credits", 49'(credits), 49'd128);
    check("rst_err", 49'(credit_err), 49'd0);
    reset_bft = 1'b1;
    tick();
  endtask

  // Waits (bounded) for ack with vld already high; returns the packet seen with it.
  task automatic wait_ack(input string tag, output logic [48:0] got);
    bit ok = 1'b0;
    got = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ack_tx2user) begin
        ok  = 1'b1;
        got = dout_tx2bft;
        break;
      end
    end
    vld_user2tx = 1'b0;
    check(tag, 49'(ok), 49'd1);
  endtask

  task automatic send_word(input logic [31:0] d, output logic [48:0] got);
    din_leaf_user2tx = d;
    vld_user2tx      = 1'b1;
    wait_ack("ack_seen", got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [48:0] got;
    int          acks;

    // Basic packet format, ack pulse width, latched destination.
    do_reset(4'd3, 4'd2);
    send_word(32'hDEADBEEF, got);
    check("pkt_deadbeef", got, pkt(4'd3, 4'd2, 7'd0, 32'hDEADBEEF));
    check("credits_127", 49'(credits), 49'd127);
    tick();
    check("ack_one_cycle", 49'(ack_tx2user), 49'd0);
    check("dout_cleared", dout_tx2bft, 49'd0);

    // Destination change after IDLE is ignored; parity word.
    dest_leaf = 4'd15;
    dest_port = 4'd9;
    send_word(32'h00000007, got);
    check("pkt_parity", got, pkt(4'd3, 4'd2, 7'd1, 32'h00000007));
`ifdef BFT_TX_PARITY_EN
    check("parity_bit", 49'(got[32]), 49'd1);
`else
    check("parity_bit", 49'(got[32]), 49'd0);
`endif
    tick();

    // Non-control packets must not return credit.
    din_bft2tx = ret_pkt(4'd1, 8'd20);
    tick();
    din_bft2tx = {1'b0, 48'd20};
    tick();
    din_bft2tx = '0;
    check("ignore_non_ctrl", 49'(credits), 49'd126);

    // Drain all 128 credits, then stall.
    do_reset(4'd9, 4'd5);
    for (int i = 0; i < 128; i++) begin
      send_word(32'hA500_0000 + 32'(i), got);
      check("stream_pkt", got, pkt(4'd9, 4'd5, 7'(i), 32'hA500_0000 + 32'(i)));
      tick();
    end
    check("credits_zero", 49'(credits), 49'd0);

    din_leaf_user2tx = 32'h1234_5678;
    vld_user2tx      = 1'b1;
    acks = 0;
    repeat (30) begin
      tick();
      if (ack_tx2user) acks++;
    end
    check("stall_no_ack", 49'(acks), 49'd0);
    check("stall_dout_zero", dout_tx2bft, 49'd0);

    din_bft2tx = ret_pkt(4'd0, 8'd64);
    tick();
    din_bft2tx = '0;
    check("credits_64", 49'(credits), 49'd64);
    wait_ack("resume_ack", got);
    check("resume_pkt_wrap", got, pkt(4'd9, 4'd5, 7'd0, 32'h1234_5678));
    check("credits_63", 49'(credits), 49'd63);
    tick();

    // Overflow saturation and sticky error.
    do_reset(4'd1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      send_word(32'(i), got);
      tick();
    end
    check("credits_125", 49'(credits), 49'd125);
    din_bft2tx = ret_pkt(4'd0, 8'd10);
    tick();
    din_bft2tx = '0;
    check("sat_credits", 49'(credits), 49'd128);
    check("err_set", 49'(credit_err), 49'd1);
    repeat (5) tick();
    check("err_sticky", 49'(credit_err), 49'd1);

    // Simultaneous send and return of one credit at credits == 5.
    for (int i = 0; i < 123; i++) begin
      send_word(32'hC0DE_0000 + 32'(i), got);
      tick();
    end
    check("credits_5", 49'(credits), 49'd5);
    check("err_still_set", 49'(credit_err), 49'd1);
    din_leaf_user2tx = 32'hFACE_0001;
    vld_user2tx      = 1'b1;
    din_bft2tx       = ret_pkt(4'd0, 8'd1);
    tick();
    din_bft2tx  = '0;
    vld_user2tx = 1'b0;
    check("simul_ack", 49'(ack_tx2user), 49'd1);
    check("simul_pkt", dout_tx2bft, pkt(4'd1, 4'd7, 7'd126, 32'hFACE_0001));
    check("simul_credits", 49'(credits), 49'd5);
    tick();

    // Only reset clears the error.
    reset_bft = 1'b0;
    tick();
    check("err_cleared", 49'(credit_err), 49'd0);
    check("credits_restored", 49'(credits), 49'd128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
